// File: rtl/register_scoreboard_if.sv
// Register scoreboard bus: ID-stage issue, WB-stage retire, pipeline flush,
// ID-stage source lookup and the status outputs of the scoreboard.
// master = pipeline side that drives requests, slave = the scoreboard itself.
interface register_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
);
  logic                issue_en;
  logic                issue_wb_en;
  logic [IDX_W-1:0]    issue_dest;
  logic                issue_ready;
  logic                retire_en;
  logic [IDX_W-1:0]    retire_dest;
  logic                flush;
  logic [IDX_W-1:0]    src1;
  logic [IDX_W-1:0]    src2;
  logic                two_src;
  logic                hazard;
  logic [NUM_REGS-1:0] busy_vec;
  logic                underflow_err;

  modport master (
    output issue_en, issue_wb_en, issue_dest,
    output retire_en, retire_dest, flush,
    output src1, src2, two_src,
    input  issue_ready, hazard, busy_vec, underflow_err
  );

  modport slave (
    input  issue_en, issue_wb_en, issue_dest,
    input  retire_en, retire_dest, flush,
    input  src1, src2, two_src,
    output issue_ready, hazard, busy_vec, underflow_err
  );
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard: writer-side bookkeeping of in-flight register writes.
// One saturating pending-write counter per architectural register is bumped
// when an instruction with a destination leaves ID and decremented when WB
// writes the register file. From those counters the block drives busy_vec,
// the RAW hazard (stall) for the ID-stage sources and issue_ready.
//
// Optional feature macro: SCOREBOARD_BYPASS_EN
//   Defined     : a same-cycle valid retire of the last pending write to a
//                 source register suppresses that source's hazard (register
//                 file writes before ID reads).
//   Not defined : hazard is a function of the registered counters only.
//
// Indices >= NUM_REGS (only possible when NUM_REGS < 2**IDX_W) never match a
// counter: issue/retire to them are ignored and such sources read as idle.
module register_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  register_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Architectural state: counters and the sticky underflow flag.
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                underflow_err_q;
  logic                underflow_err_d;

  // Counter values seen by each lookup port (zero for out-of-range indices).
  logic [CNT_W-1:0]    issue_cnt_s;
  logic [CNT_W-1:0]    retire_cnt_s;
  logic [CNT_W-1:0]    src1_cnt_s;
  logic [CNT_W-1:0]    src2_cnt_s;
  logic                retire_hit_s;

  // Decoded control.
  logic                issue_ready_s;
  logic                issue_accept_s;
  logic                retire_valid_s;
  logic                underflow_set_s;
  logic [NUM_REGS-1:0] inc_vec_s;
  logic [NUM_REGS-1:0] dec_vec_s;

  // Outputs before they are driven onto the interface.
  logic                busy1_s;
  logic                busy2_s;
  logic                bypass1_s;
  logic                bypass2_s;
  logic                hazard_s;
  logic [NUM_REGS-1:0] busy_vec_s;

  // One-hot read of the counter array for the issue, retire and source ports.
  always_comb begin
    issue_cnt_s  = CNT_ZERO;
    retire_cnt_s = CNT_ZERO;
    src1_cnt_s   = CNT_ZERO;
    src2_cnt_s   = CNT_ZERO;
    retire_hit_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      issue_cnt_s  = issue_cnt_s  | ((sb.issue_dest  == IDX_W'(r)) ? cnt_q[r] : CNT_ZERO);
      retire_cnt_s = retire_cnt_s | ((sb.retire_dest == IDX_W'(r)) ? cnt_q[r] : CNT_ZERO);
      src1_cnt_s   = src1_cnt_s   | ((sb.src1        == IDX_W'(r)) ? cnt_q[r] : CNT_ZERO);
      src2_cnt_s   = src2_cnt_s   | ((sb.src2        == IDX_W'(r)) ? cnt_q[r] : CNT_ZERO);
      retire_hit_s = retire_hit_s | (sb.retire_dest == IDX_W'(r));
    end
  end

  // Issue acceptance, retire qualification and underflow detection.
  // issue_ready looks at the registered count only, never at a same-cycle
  // retire, so a saturated register refuses issue even while it retires.
  always_comb begin
    issue_ready_s   = (issue_cnt_s != CNT_MAX);
    issue_accept_s  = sb.issue_en & sb.issue_wb_en & issue_ready_s;
    retire_valid_s  = sb.retire_en & (retire_cnt_s != CNT_ZERO);
    underflow_set_s = sb.retire_en & retire_hit_s & (retire_cnt_s == CNT_ZERO);
    underflow_err_d = underflow_err_q | underflow_set_s;
  end

  // Per-register increment/decrement strobes.
  always_comb begin
    inc_vec_s = {NUM_REGS{1'b0}};
    dec_vec_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec_s[r] = issue_accept_s & (sb.issue_dest  == IDX_W'(r));
      dec_vec_s[r] = retire_valid_s & (sb.retire_dest == IDX_W'(r));
    end
  end

  // Next counter values: flush wins, simultaneous inc/dec cancel out.
  // The guards above keep every counter inside [0, CNT_MAX], so no wrap.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb.flush) begin
        cnt_d[r] = CNT_ZERO;
      end else begin
        case ({inc_vec_s[r], dec_vec_s[r]})
          2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
          2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  // Busy vector: one bit per register with any write still in flight.
  always_comb begin
    busy_vec_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec_s[r] = (cnt_q[r] != CNT_ZERO);
    end
  end

  // RAW hazard for the ID-stage sources; with bypass, a valid retire of the
  // last pending write to a source lets ID read the freshly written value.
  always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
    bypass1_s = retire_valid_s & (sb.retire_dest == sb.src1) & (src1_cnt_s == CNT_ONE);
    bypass2_s = retire_valid_s & (sb.retire_dest == sb.src2) & (src2_cnt_s == CNT_ONE);
`else
    bypass1_s = 1'b0;
    bypass2_s = 1'b0;
`endif
    busy1_s  = (src1_cnt_s != CNT_ZERO) & ~bypass1_s;
    busy2_s  = sb.two_src & (src2_cnt_s != CNT_ZERO) & ~bypass2_s;
    hazard_s = busy1_s | busy2_s;
  end

  // State update; rst clears everything at once, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      underflow_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      underflow_err_q <= underflow_err_d;
    end
  end

  assign sb.issue_ready   = issue_ready_s;
  assign sb.hazard        = hazard_s;
  assign sb.busy_vec      = busy_vec_s;
  assign sb.underflow_err = underflow_err_q;

endmodule
